// File: rtl/axi_lite_kernel_regs.sv
// Kernel-side AXI-Lite register file. The host writes a descriptor bank, and a write to the last
// descriptor word starts the kernel. Kernel results are captured and signalled by a req/ack interrupt.
module axi_lite_kernel_regs #(
    parameter int          LITE_AWIDTH     = 32,
    parameter int          LITE_DWIDTH     = 32,
    parameter int          WRITEREG_NUMBER = 16,
    parameter int          READREG_NUMBER  = 1,
    parameter int          READ_BASE_ADDR  = 'h100,
    parameter logic [63:0] INT_SRC         = 64'h0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [LITE_AWIDTH-1:0]        s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [LITE_DWIDTH-1:0]        s_axi_wdata,
    input  logic [LITE_DWIDTH/8-1:0]      s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [LITE_AWIDTH-1:0]        s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [LITE_DWIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [WRITEREG_NUMBER*32-1:0] desc_data,
    output logic                          kernel_start,
    input  logic                          kernel_done,
    input  logic [READREG_NUMBER*32-1:0]  kernel_result,
    output logic                          interrupt_req,
    output logic [63:0]                   interrupt_src,
    output logic [8:0]                    interrupt_ctx,
    input  logic                          interrupt_ack
);
    localparam int IW = LITE_AWIDTH - 2;

    logic                          r_aw_done;
    logic                          r_w_done;
    logic [IW-1:0]                 r_aw_idx;
    logic [LITE_DWIDTH-1:0]        r_wdata;
    logic [LITE_DWIDTH/8-1:0]      r_wstrb;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [LITE_DWIDTH-1:0]        r_rdata;
    logic [WRITEREG_NUMBER*32-1:0] r_desc;
    logic [READREG_NUMBER*32-1:0]  r_result;
    logic                          r_kernel_start;
    logic                          r_busy;
    logic                          r_irq;
    logic [8:0]                    r_ctx;

    logic                          w_wr_exec;
    logic                          w_wr_ok;
    logic                          w_start;
    logic [WRITEREG_NUMBER*32-1:0] w_desc_next;
    logic [IW-1:0]                 w_ar_idx;
    logic [LITE_DWIDTH-1:0]        w_rd_data;
    logic                          w_rd_hit;
    logic                          w_unused;

    assign w_wr_exec = r_aw_done && r_w_done && !r_bvalid;
    assign w_wr_ok   = (r_aw_idx < IW'(WRITEREG_NUMBER)) && !r_busy;
    assign w_start   = w_wr_exec && w_wr_ok && (r_aw_idx == IW'(WRITEREG_NUMBER - 1));
    assign w_ar_idx  = s_axi_araddr[LITE_AWIDTH-1:2];
    assign w_unused  = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        w_desc_next = r_desc;
        for (int i = 0; i < WRITEREG_NUMBER; i++) begin
            for (int b = 0; b < LITE_DWIDTH/8; b++) begin
                if (r_aw_idx == IW'(i) && r_wstrb[b]) begin
                    w_desc_next[32*i + 8*b +: 8] = r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Descriptor decode is evaluated last so it wins if the two windows ever overlap.
    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        for (int j = 0; j < READREG_NUMBER; j++) begin
            if (w_ar_idx == IW'(READ_BASE_ADDR/4 + j)) begin
                w_rd_data = r_result[32*j +: 32];
                w_rd_hit  = 1'b1;
            end
        end
        for (int i = 0; i < WRITEREG_NUMBER; i++) begin
            if (w_ar_idx == IW'(i)) begin
                w_rd_data = r_desc[32*i +: 32];
                w_rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_desc    <= '0;
        end else begin
            if (s_axi_awvalid && !r_aw_done) begin
                r_aw_done <= 1'b1;
                r_aw_idx  <= s_axi_awaddr[LITE_AWIDTH-1:2];
            end
            if (s_axi_wvalid && !r_w_done) begin
                r_w_done <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_wr_exec) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
                if (w_wr_ok) begin
                    r_desc <= w_desc_next;
                end
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else if (!r_rvalid && s_axi_arvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_hit ? 2'b00 : 2'b10;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // A done coinciding with the start pulse belongs to a previous run and is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_kernel_start <= 1'b0;
            r_busy         <= 1'b0;
            r_irq          <= 1'b0;
            r_ctx          <= '0;
            r_result       <= '0;
        end else if (w_start) begin
            r_kernel_start <= 1'b1;
            r_busy         <= 1'b1;
            r_ctx          <= w_desc_next[8:0];
        end else begin
            r_kernel_start <= 1'b0;
            if (r_irq && interrupt_ack) begin
                r_irq  <= 1'b0;
                r_busy <= 1'b0;
            end else if (kernel_done && r_busy && !r_kernel_start) begin
                r_result <= kernel_result;
                r_irq    <= 1'b1;
            end
        end
    end

    assign s_axi_awready = !r_aw_done;
    assign s_axi_wready  = !r_w_done;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = !r_rvalid;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign desc_data     = r_desc;
    assign kernel_start  = r_kernel_start;
    assign interrupt_req = r_irq;
    assign interrupt_ctx = r_ctx;
    assign interrupt_src = INT_SRC;

endmodule

// File: tb/tb_axi_lite_kernel_regs.sv
// Bench for axi_lite_kernel_regs: directed scenarios plus randomized AXI-Lite traffic,
// checked against a transaction-level model of the register file and interrupt handshake.
module tb_axi_lite_kernel_regs;
    logic         clk = 1'b0;
    logic         resetn;
    logic [31:0]  s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
    logic [2:0]   s_axi_awprot, s_axi_arprot;
    logic [3:0]   s_axi_wstrb;
    logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [1:0]   s_axi_bresp, s_axi_rresp;
    logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic         s_axi_rvalid, s_axi_rready;
    logic [511:0] desc_data;
    logic         kernel_start, kernel_done, interrupt_req, interrupt_ack;
    logic [31:0]  kernel_result;
    logic [63:0]  interrupt_src;
    logic [8:0]   interrupt_ctx;

    always #5 clk = ~clk;

    axi_lite_kernel_regs dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .desc_data(desc_data), .kernel_start(kernel_start),
        .kernel_done(kernel_done), .kernel_result(kernel_result), .interrupt_req(interrupt_req),
        .interrupt_src(interrupt_src), .interrupt_ctx(interrupt_ctx), .interrupt_ack(interrupt_ack)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_desc [16];
    logic [31:0] m_result;
    logic        m_busy, m_irq, m_start_exp;
    logic [8:0]  m_ctx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_desc[i] = 32'h0;
        m_result = 32'h0; m_busy = 1'b0; m_irq = 1'b0; m_start_exp = 1'b0; m_ctx = 9'h0;
    endfunction

    function automatic logic [1:0] model_wresp(input logic [31:0] addr);
        return (addr < 32'h40 && !m_busy) ? 2'b00 : 2'b10;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int idx;
        if (addr < 32'h40 && !m_busy) begin
            idx = int'(addr / 4);
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_desc[idx][8*b +: 8] = data[8*b +: 8];
            if (idx == 15) begin
                m_busy = 1'b1; m_ctx = m_desc[0][8:0]; m_start_exp = 1'b1;
            end
        end
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        if (addr < 32'h40) begin
            data = m_desc[int'(addr / 4)]; resp = 2'b00;
        end else if (addr >= 32'h100 && addr < 32'h104) begin
            data = m_result; resp = 2'b00;
        end else begin
            data = 32'h0; resp = 2'b10;
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 16; i++)
                    chk($sformatf("desc_data[%0d]", i), 64'(desc_data[32*i +: 32]), 64'(m_desc[i]));
                chk("interrupt_req", 64'(interrupt_req), 64'(m_irq));
                chk("interrupt_ctx", 64'(interrupt_ctx), 64'(m_ctx));
                chk("interrupt_src", interrupt_src, 64'h0);
                chk("kernel_start", 64'(kernel_start), 64'(m_start_exp));
                m_start_exp = 1'b0;
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output logic started);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        logic [1:0] exp_resp;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        while (!(aw_done && w_done) && cyc < 64) begin
            s_axi_awvalid = !aw_done && cyc >= aw_dly;
            s_axi_wvalid  = !w_done && cyc >= w_dly;
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            if (aw_done) chk("awready_low_after_aw", 64'(s_axi_awready), 64'h0);
            if (w_done) chk("wready_low_after_w", 64'(s_axi_wready), 64'h0);
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            n_checks++; n_errors++;
            $display("FAIL wr_handshake_timeout: got aw=%0d w=%0d want both", aw_done, w_done);
            resp = 2'b11; started = 1'b0;
            return;
        end
        chk("bvalid_not_early", 64'(s_axi_bvalid), 64'h0);
        exp_resp = model_wresp(addr);
        @(posedge clk); #1;
        model_write(addr, data, strb);
        chk("bvalid_rise", 64'(s_axi_bvalid), 64'h1);
        chk("bresp", 64'(s_axi_bresp), 64'(exp_resp));
        resp = s_axi_bresp; started = kernel_start;
        repeat (b_dly) begin
            chk("awready_held_low", 64'(s_axi_awready), 64'h0);
            chk("wready_held_low", 64'(s_axi_wready), 64'h0);
            @(posedge clk); #1;
            chk("bvalid_hold", 64'(s_axi_bvalid), 64'h1);
            chk("bresp_hold", 64'(s_axi_bresp), 64'(exp_resp));
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        chk("bvalid_drop", 64'(s_axi_bvalid), 64'h0);
        chk("awready_return", 64'(s_axi_awready), 64'h1);
        chk("wready_return", 64'(s_axi_wready), 64'h1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        bit done = 0, hs;
        int cyc = 0;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        s_axi_araddr = addr;
        while (!done && cyc < 64) begin
            s_axi_arvalid = cyc >= ar_dly;
            hs = s_axi_arvalid && s_axi_arready;
            if (hs) begin
                #1;
                model_read(addr, exp_d, exp_r);
            end
            @(posedge clk); #1;
            if (hs) done = 1;
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL rd_handshake_timeout: got no ar handshake want one");
            data = 32'hx; resp = 2'b11;
            return;
        end
        chk("rvalid_rise", 64'(s_axi_rvalid), 64'h1);
        chk("rdata", 64'(s_axi_rdata), 64'(exp_d));
        chk("rresp", 64'(s_axi_rresp), 64'(exp_r));
        chk("arready_low", 64'(s_axi_arready), 64'h0);
        data = s_axi_rdata; resp = s_axi_rresp;
        repeat (r_dly) begin
            @(posedge clk); #1;
            chk("rvalid_hold", 64'(s_axi_rvalid), 64'h1);
            chk("rdata_hold", 64'(s_axi_rdata), 64'(exp_d));
            chk("rresp_hold", 64'(s_axi_rresp), 64'(exp_r));
            chk("arready_held_low", 64'(s_axi_arready), 64'h0);
        end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        chk("rvalid_drop", 64'(s_axi_rvalid), 64'h0);
        chk("arready_return", 64'(s_axi_arready), 64'h1);
    endtask

    task automatic kdone(input logic [31:0] res);
        bit take;
        kernel_result = res; kernel_done = 1'b1;
        take = m_busy && !m_start_exp;
        @(posedge clk); #1;
        kernel_done = 1'b0;
        if (take) begin
            m_result = res; m_irq = 1'b1;
        end
    endtask

    task automatic do_ack();
        bit take;
        interrupt_ack = 1'b1;
        take = m_irq;
        @(posedge clk); #1;
        interrupt_ack = 1'b0;
        if (take) begin
            m_irq = 1'b0; m_busy = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp, rr;
        logic [31:0] d, a;
        logic        st;
        int          op, cyc;
        resetn = 1'b0;
        s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
        s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = 0; s_axi_arprot = 0; s_axi_arvalid = 0;
        s_axi_rready = 0; kernel_done = 0; kernel_result = 0; interrupt_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 64'(s_axi_awready), 64'h1);
        chk("rst_wready", 64'(s_axi_wready), 64'h1);
        chk("rst_arready", 64'(s_axi_arready), 64'h1);
        chk("rst_bvalid", 64'(s_axi_bvalid), 64'h0);
        chk("rst_rvalid", 64'(s_axi_rvalid), 64'h0);
        chk("rst_desc", 64'(|desc_data), 64'h0);
        resetn = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;

        axi_write(32'h00, 32'hA5A5_0001, 4'hF, 0, 0, 0, resp, st);
        chk("t1_bresp", 64'(resp), 64'h0);
        chk("t1_desc0", 64'(desc_data[31:0]), 64'hA5A5_0001);
        chk("t1_no_start", 64'(st), 64'h0);

        axi_write(32'h3C, 32'h1234_5678, 4'b0011, 3, 0, 0, resp, st);
        chk("t2_bresp", 64'(resp), 64'h0);
        chk("t2_desc15", 64'(desc_data[511:480]), 64'h0000_5678);
        chk("t2_start", 64'(st), 64'h1);
        chk("t2_ctx", 64'(interrupt_ctx), 64'h001);

        axi_write(32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, st);
        chk("t3_busy_slverr", 64'(resp), 64'h2);
        chk("t3_desc1", 64'(desc_data[63:32]), 64'h0);
        axi_read(32'h200, 0, 0, d, rr);
        chk("t3_rd200_data", 64'(d), 64'h0);
        chk("t3_rd200_resp", 64'(rr), 64'h2);

        kdone(32'hDEAD_BEEF);
        chk("t4_req_set", 64'(interrupt_req), 64'h1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("t4_req_hold", 64'(interrupt_req), 64'h1);
        end
        do_ack();
        chk("t4_req_clear", 64'(interrupt_req), 64'h0);
        axi_write(32'h04, 32'h0000_00C3, 4'h1, 0, 0, 0, resp, st);
        chk("t4_idle_ok", 64'(resp), 64'h0);
        axi_read(32'h100, 0, 0, d, rr);
        chk("t4_result", 64'(d), 64'hDEAD_BEEF);
        chk("t4_result_resp", 64'(rr), 64'h0);
        axi_read(32'h103, 1, 0, d, rr);
        chk("t4_result_lowbits", 64'(d), 64'hDEAD_BEEF);

        fork
            axi_write(32'h08, 32'h55AA_55AA, 4'hF, 1, 0, 4, resp, st);
            axi_read(32'h00, 0, 4, d, rr);
        join
        chk("t5_bresp", 64'(resp), 64'h0);
        chk("t5_rdata", 64'(d), 64'hA5A5_0001);

        fork
            axi_write(32'h3C, 32'hFFFF_0000, 4'hC, 0, 0, 0, resp, st);
            begin
                @(posedge clk); @(posedge clk); #2;
                kdone(32'h1111_1111);
            end
        join
        chk("t6_start", 64'(st), 64'h1);
        chk("t6_done_ignored", 64'(interrupt_req), 64'h0);
        kdone(32'h2222_2222);
        fork
            kdone(32'h3333_3333);
            axi_read(32'h100, 0, 0, d, rr);
        join
        chk("t6_read_old", 64'(d), 64'h2222_2222);
        do_ack();
        axi_read(32'h100, 0, 0, d, rr);
        chk("t6_read_new", 64'(d), 64'h3333_3333);
        do_ack();

        for (int k = 0; k < 250; k++) begin
            op = int'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0: a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                1: a = 32'h3C;
                2: a = $urandom;
                default: a = 32'h100 + 32'($urandom_range(0, 7));
            endcase
            if (op <= 3) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), resp, st);
            end else if (op <= 5) begin
                axi_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), d, rr);
            end else if (op == 6) begin
                kdone($urandom);
            end else if (op == 7) begin
                do_ack();
            end else if (op == 8) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end else begin
                fork
                    axi_write({26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'hF,
                              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                              int'($urandom_range(0, 2)), resp, st);
                    axi_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), d, rr);
                join
            end
        end

        if (m_busy && !m_irq) kdone(32'h0BAD_F00D);
        if (m_irq) do_ack();
        axi_write(32'h3C, 32'h0000_0001, 4'hF, 0, 0, 0, resp, st);
        kdone(32'hCAFE_0001);
        s_axi_awaddr = 32'h10; s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h3C;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        cyc = 0;
        while (!s_axi_bvalid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t7_pre_bvalid", 64'(s_axi_bvalid), 64'h1);
        chk("t7_pre_req", 64'(interrupt_req), 64'h1);
        chk("t7_pre_rdata", 64'(s_axi_rdata), 64'h0000_0001);
        #2;
        chk_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t7_awready", 64'(s_axi_awready), 64'h1);
        chk("t7_wready", 64'(s_axi_wready), 64'h1);
        chk("t7_arready", 64'(s_axi_arready), 64'h1);
        chk("t7_bvalid", 64'(s_axi_bvalid), 64'h0);
        chk("t7_bresp", 64'(s_axi_bresp), 64'h0);
        chk("t7_rvalid", 64'(s_axi_rvalid), 64'h0);
        chk("t7_rresp", 64'(s_axi_rresp), 64'h0);
        chk("t7_rdata", 64'(s_axi_rdata), 64'h0);
        chk("t7_kernel_start", 64'(kernel_start), 64'h0);
        chk("t7_req", 64'(interrupt_req), 64'h0);
        chk("t7_ctx", 64'(interrupt_ctx), 64'h0);
        chk("t7_desc", 64'(|desc_data), 64'h0);
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1; chk_en = 1'b1;
        @(posedge clk); #1;
        axi_read(32'h00, 0, 0, d, rr);
        chk("t7_rd0", 64'(d), 64'h0);
        axi_read(32'h3C, 0, 0, d, rr);
        chk("t7_rd15", 64'(d), 64'h0);
        axi_read(32'h100, 0, 0, d, rr);
        chk("t7_rdres", 64'(d), 64'h0);
        axi_write(32'h3C, 32'h0000_0002, 4'hF, 0, 0, 0, resp, st);
        chk("t7_start_after_reset", 64'(st), 64'h1);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_kernel_regs.md
Name: axi_lite_kernel_regs

Overview:
AXI-Lite slave register file on the kernel side of the action's AXI-Lite control path. It answers the descriptor writes and result reads issued by the host-side initiator. It presents the written descriptor to the kernel and pulses kernel_start. It captures kernel results and raises an interrupt request with a four-phase req/ack handshake.

Parameters:
LITE_AWIDTH, 32, AXI-Lite address width
LITE_DWIDTH, 32, AXI-Lite data width (only 32 supported)
WRITEREG_NUMBER, 16, number of 32-bit descriptor registers at offsets 0x00..(WRITEREG_NUMBER-1)*4
READREG_NUMBER, 1, number of 32-bit result registers
READ_BASE_ADDR, 'h100, byte offset of result register 0
INT_SRC, 64'h0, value driven on interrupt_src

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
s_axi_awaddr  in  LITE_AWIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  LITE_DWIDTH  write data
s_axi_wstrb  in  LITE_DWIDTH/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  LITE_AWIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  LITE_DWIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
desc_data  out  WRITEREG_NUMBER*32  descriptor bank; reg i at bits [32i+31:32i]
kernel_start  out  1  one-cycle start pulse
kernel_done  in  1  one-cycle completion pulse from kernel
kernel_result  in  READREG_NUMBER*32  result words, sampled on kernel_done
interrupt_req  out  1  interrupt request
interrupt_src  out  64  equals INT_SRC
interrupt_ctx  out  9  context for the interrupt
interrupt_ack  in  1  interrupt acknowledge

Behaviour:
- Reset: resetn is asynchronous, active-low; clock is clk. On reset: awready=1, wready=1, arready=1; bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0; kernel_start=0; interrupt_req=0; busy=0; descriptor and result registers=0; interrupt_ctx=0. Reset mid-transaction drops any pending beat and returns no response.
- Decode uses byte address with bits [1:0] ignored.
- Write path:
  - AW and W are accepted independently. awready drops after an AW handshake until the response completes; wready behaves the same for W.
  - Once both address and data are latched, the write executes on the next cycle and bvalid rises in that same cycle.
  - Minimum latency is 1 cycle from simultaneous AW/W handshake to bvalid.
  - bvalid holds until bready; awready and wready return to 1 the cycle after the B handshake.
- Write response:
  - Address in descriptor range and busy=0: bytes with wstrb set are updated, bresp=OKAY (2'b00).
  - Address in descriptor range and busy=1: no update, bresp=SLVERR (2'b10).
  - Address outside descriptor range: no update, bresp=SLVERR.
- Start:
  - An OKAY write to register WRITEREG_NUMBER-1 pulses kernel_start for exactly one cycle, coincident with the first cycle of bvalid.
  - In the same cycle busy is set and interrupt_ctx latches descriptor reg0[8:0] using the post-write value.
  - desc_data always reflects the register bank.
- Read path:
  - arready=1 when idle. After an AR handshake, arready=0 and rvalid=1 on the next cycle.
  - rvalid holds until rready; arready returns to 1 the cycle after the R handshake.
  - Descriptor range: rdata = that register, rresp=OKAY.
  - [READ_BASE_ADDR, READ_BASE_ADDR+READREG_NUMBER*4): rdata = result register, rresp=OKAY.
  - Otherwise: rdata=0, rresp=SLVERR.
  - rdata and rresp stay stable while rvalid=1.
- Completion:
  - kernel_done with busy=1 captures kernel_result into the result registers and sets interrupt_req on the next edge.
  - kernel_done with busy=0 is ignored.
  - A kernel_done in the same cycle as kernel_start is ignored.
- Interrupt:
  - interrupt_req holds until interrupt_ack is sampled high. interrupt_req then clears and busy clears on that edge.
  - interrupt_ack while interrupt_req=0 is ignored.
  - interrupt_src = INT_SRC constant.
- Read and write channels are fully independent and may complete in the same cycle. A read of a result register in the same cycle as its capture returns the old value.

Test Plan:
- Write 0xA5A5_0001 to 0x00 with wstrb=4'hF, AW and W in the same cycle -> bvalid 1 cycle later with bresp=00; desc_data[31:0]=0xA5A5_0001; kernel_start stays 0.
- W presented 3 cycles before AW; write 0x1234_5678 to 0x3C, wstrb=4'b0011 -> bytes [15:0] updated only; kernel_start pulses 1 cycle with bvalid; busy=1; interrupt_ctx=0x001.
- While busy, write to 0x04 -> bresp=10 and the register is unchanged; read 0x200 -> rdata=0 and rresp=10.
- kernel_done with kernel_result=0xDEAD_BEEF -> interrupt_req=1 next cycle; hold interrupt_ack low 5 cycles -> req stays 1; raise ack -> req=0 and busy=0; read 0x100 -> 0xDEAD_BEEF with rresp=00.
- bready and rready held low 4 cycles -> bvalid, rvalid and data stable; awready, wready and arready stay 0 until the handshake completes.
- Assert resetn=0 while bvalid=1 and interrupt_req=1 -> all outputs return to reset values asynchronously; the descriptor bank reads back 0.
